// File: rtl/bm_dag1_seq_ctrl_pkg.sv
// Shared types and per-state lookup tables for the sequenced dag1 datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bm_dag1_pkg;

    // Controller states, one shared-unit operation per state between IDLE and DONE
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        SUM  = 3'd4,
        DIFF = 3'd5,
        DONE = 3'd6
    } state_t;

    // Shared arithmetic unit operation
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // Operand sources that can feed either side of the shared unit
    typedef enum logic [2:0] {
        SRC_RA  = 3'd0,
        SRC_RB  = 3'd1,
        SRC_T1  = 3'd2,
        SRC_T2  = 3'd3,
        SRC_T3  = 3'd4,
        SRC_ACC = 3'd5
    } src_t;

    // Operation the shared unit performs in each state.
    // Only T2 (ra-rb) and DIFF (acc-t3) subtract; idle states default to add.
    function automatic op_t state_op(state_t s);
        state_op = OP_ADD;
        case (s)
            T2, DIFF: state_op = OP_SUB;
            default:  state_op = OP_ADD;
        endcase
    endfunction

    // Left-hand operand source per state
    function automatic src_t state_xsel(state_t s);
        state_xsel = SRC_RA;
        case (s)
            T1:      state_xsel = SRC_RA;
            T2:      state_xsel = SRC_RA;
            T3:      state_xsel = SRC_RB;
            SUM:     state_xsel = SRC_T1;
            DIFF:    state_xsel = SRC_ACC;
            default: state_xsel = SRC_RA;
        endcase
    endfunction

    // Right-hand operand source per state
    function automatic src_t state_ysel(state_t s);
        state_ysel = SRC_RB;
        case (s)
            T1:      state_ysel = SRC_RB;
            T2:      state_ysel = SRC_RB;
            T3:      state_ysel = SRC_RB;
            SUM:     state_ysel = SRC_T2;
            DIFF:    state_ysel = SRC_T3;
            default: state_ysel = SRC_RB;
        endcase
    endfunction

endpackage

// File: rtl/bm_dag1_seq_ctrl_if.sv
// Producer/consumer handshake bundle plus status outputs of the dag1 sequencer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the operand and the result side.
interface bm_dag1_seq_ctrl_if #(
    parameter int BITS     = 2,
    parameter int CNT_BITS = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [BITS-1:0]     a_in;
    logic [BITS-1:0]     b_in;
    logic                out_valid;
    logic                out_ready;
    logic [BITS-1:0]     out;
    logic                busy;
    logic [CNT_BITS-1:0] done_cnt;

    // Environment side: drives operands and result acceptance
    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, out, busy, done_cnt
    );

    // Sequencer side
    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, out, busy, done_cnt
    );
endinterface

// File: rtl/bm_dag1_alu.sv
// Shared add/subtract unit, modulo 2^BITS (carry and borrow discarded).
// Latency: combinational.
// Backpressure: none.
module bm_dag1_alu
    import bm_dag1_pkg::*;
#(
    parameter int BITS = 2
) (
    input  logic [BITS-1:0] i_x,
    input  logic [BITS-1:0] i_y,
    input  op_t             i_op,
    output logic [BITS-1:0] o_r
);

    // Single adder/subtractor; result truncated to BITS
    always_comb begin
        o_r = '0;
        if (i_op == OP_SUB) begin
            o_r = i_x - i_y;
        end else begin
            o_r = i_x + i_y;
        end
    end

endmodule

// File: rtl/bm_dag1_seq_ctrl.sv
// Computes out = (a+b)+(a-b)-(b+b) mod 2^BITS through one shared add/sub unit.
// Latency: accept edge E -> out_valid after E+5; next accept no earlier than handoff+1.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module bm_dag1_seq_ctrl
    import bm_dag1_pkg::*;
#(
    parameter int BITS     = 2,
    parameter int CNT_BITS = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    bm_dag1_seq_ctrl_if.slave     bus
);

    // Controller state
    state_t              r_state;

    // Captured operands, graph temporaries and result
    logic [BITS-1:0]     r_ra;
    logic [BITS-1:0]     r_rb;
    logic [BITS-1:0]     r_t1;
    logic [BITS-1:0]     r_t2;
    logic [BITS-1:0]     r_t3;
    logic [BITS-1:0]     r_acc;
    logic [BITS-1:0]     r_out;

    // Registered handshake/status outputs
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;
    logic [CNT_BITS-1:0] r_done_cnt;

    // Shared unit operands, op and result
    src_t                w_xsel;
    src_t                w_ysel;
    op_t                 w_op;
    logic [BITS-1:0]     w_x;
    logic [BITS-1:0]     w_y;
    logic [BITS-1:0]     w_r;

    // Per-state operation and operand selection, decoded from state only
    always_comb begin
        w_op   = state_op(r_state);
        w_xsel = state_xsel(r_state);
        w_ysel = state_ysel(r_state);
    end

    // Left operand source mux
    always_comb begin
        w_x = '0;
        case (w_xsel)
            SRC_RA:  w_x = r_ra;
            SRC_RB:  w_x = r_rb;
            SRC_T1:  w_x = r_t1;
            SRC_T2:  w_x = r_t2;
            SRC_T3:  w_x = r_t3;
            SRC_ACC: w_x = r_acc;
            default: w_x = '0;
        endcase
    end

    // Right operand source mux
    always_comb begin
        w_y = '0;
        case (w_ysel)
            SRC_RA:  w_y = r_ra;
            SRC_RB:  w_y = r_rb;
            SRC_T1:  w_y = r_t1;
            SRC_T2:  w_y = r_t2;
            SRC_T3:  w_y = r_t3;
            SRC_ACC: w_y = r_acc;
            default: w_y = '0;
        endcase
    end

    bm_dag1_alu #(
        .BITS (BITS)
    ) u_alu (
        .i_x  (w_x),
        .i_y  (w_y),
        .i_op (w_op),
        .o_r  (w_r)
    );

    // Controller: steps the five graph operations and owns every datapath register.
    // Handshake outputs are updated alongside the state so they stay registered.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_ra        <= '0;
            r_rb        <= '0;
            r_t1        <= '0;
            r_t2        <= '0;
            r_t3        <= '0;
            r_acc       <= '0;
            r_out       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Operands are sampled only here; later input activity is ignored
                    if (bus.in_valid && r_in_ready) begin
                        r_ra       <= bus.a_in;
                        r_rb       <= bus.b_in;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= T1;
                    end
                end
                T1: begin
                    r_t1    <= w_r;
                    r_state <= T2;
                end
                T2: begin
                    r_t2    <= w_r;
                    r_state <= T3;
                end
                T3: begin
                    r_t3    <= w_r;
                    r_state <= SUM;
                end
                SUM: begin
                    r_acc   <= w_r;
                    r_state <= DIFF;
                end
                DIFF: begin
                    r_out       <= w_r;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    // Result and out_valid hold until the consumer takes them
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_done_cnt  <= r_done_cnt + CNT_BITS'(1);
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.busy      = r_busy;
    assign bus.done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_bm_dag1_seq_ctrl.sv
// Self-checking bench: two sequencer instances (BITS=2/CNT_BITS=2 and BITS=8/CNT_BITS=8)
// share one stimulus stream; results compared against arithmetic reference values.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_bm_dag1_seq_ctrl;

    logic       clock;
    logic       reset_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a_drv;
    logic [7:0] b_drv;

    int n_asrt = 0;
    int n_fail = 0;
    int cnt2   = 0;
    int cnt8   = 0;

    bm_dag1_seq_ctrl_if #(.BITS(2), .CNT_BITS(2)) if2 ();
    bm_dag1_seq_ctrl_if #(.BITS(8), .CNT_BITS(8)) if8 ();

    assign if2.in_valid  = in_valid;
    assign if2.out_ready = out_ready;
    assign if2.a_in      = a_drv[1:0];
    assign if2.b_in      = b_drv[1:0];
    assign if8.in_valid  = in_valid;
    assign if8.out_ready = out_ready;
    assign if8.a_in      = a_drv;
    assign if8.b_in      = b_drv;

    bm_dag1_seq_ctrl #(.BITS(2), .CNT_BITS(2)) u_dut2 (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .bus       (if2.slave)
    );

    bm_dag1_seq_ctrl #(.BITS(8), .CNT_BITS(8)) u_dut8 (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .bus       (if8.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: (a+b)+(a-b)-(b+b) on operands reduced to the instance width, mod 2^bits
    function automatic int ref_out(input int a, input int b, input int bits);
        int m;
        int am;
        int bm;
        int raw;
        m   = 1 << bits;
        am  = a % m;
        bm  = b % m;
        raw = (am + bm) + (am - bm) - (bm + bm);
        return ((raw % m) + m) % m;
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready2"},  32'(if2.in_ready),  1);
        chk({tag, "_in_ready8"},  32'(if8.in_ready),  1);
        chk({tag, "_out_valid2"}, 32'(if2.out_valid), 0);
        chk({tag, "_out_valid8"}, 32'(if8.out_valid), 0);
        chk({tag, "_busy2"},      32'(if2.busy),      0);
        chk({tag, "_busy8"},      32'(if8.busy),      0);
    endtask

    // One full transaction starting from IDLE at a falling edge; hold = cycles of
    // out_ready=0 in DONE before the handoff. Operands and in_valid are scrambled
    // while the block is busy or holding its result.
    task automatic run_txn(input int a, input int b, input int hold);
        int e2;
        int e8;
        e2 = ref_out(a, b, 2);
        e8 = ref_out(a, b, 8);
        chk("pre_in_ready2", 32'(if2.in_ready), 1);
        chk("pre_in_ready8", 32'(if8.in_ready), 1);
        in_valid  = 1'b1;
        a_drv     = 8'(a);
        b_drv     = 8'(b);
        out_ready = 1'b0;
        tick();
        // Five busy cycles T1..DIFF
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("busy2_c%0d", k),      32'(if2.busy),      1);
            chk($sformatf("busy8_c%0d", k),      32'(if8.busy),      1);
            chk($sformatf("out_valid2_c%0d", k), 32'(if2.out_valid), 0);
            chk($sformatf("out_valid8_c%0d", k), 32'(if8.out_valid), 0);
            chk($sformatf("in_ready8_c%0d", k),  32'(if8.in_ready),  0);
            in_valid  = 1'($urandom_range(0, 1));
            a_drv     = 8'($urandom);
            b_drv     = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        // DONE reached exactly five edges after accept
        chk("done_out_valid2", 32'(if2.out_valid), 1);
        chk("done_out_valid8", 32'(if8.out_valid), 1);
        chk("done_busy8",      32'(if8.busy),      0);
        chk("done_in_ready2",  32'(if2.in_ready),  0);
        chk("done_out2",       32'(if2.out),       32'(e2));
        chk("done_out8",       32'(if8.out),       32'(e8));
        chk("done_cnt2_hold",  32'(if2.done_cnt),  32'(cnt2));
        chk("done_cnt8_hold",  32'(if8.done_cnt),  32'(cnt8));
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            a_drv     = 8'($urandom);
            b_drv     = 8'($urandom);
            tick();
            chk($sformatf("bp_out_valid8_h%0d", h), 32'(if8.out_valid), 1);
            chk($sformatf("bp_out2_h%0d", h),       32'(if2.out),       32'(e2));
            chk($sformatf("bp_out8_h%0d", h),       32'(if8.out),       32'(e8));
            chk($sformatf("bp_in_ready8_h%0d", h),  32'(if8.in_ready),  0);
            chk($sformatf("bp_cnt8_h%0d", h),       32'(if8.done_cnt),  32'(cnt8));
        end
        out_ready = 1'b1;
        tick();
        cnt2 = (cnt2 + 1) % 4;
        cnt8 = (cnt8 + 1) % 256;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_idle("handoff");
        chk("handoff_cnt2", 32'(if2.done_cnt), 32'(cnt2));
        chk("handoff_cnt8", 32'(if8.done_cnt), 32'(cnt8));
    endtask

    initial begin
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_drv     = 8'd0;
        b_drv     = 8'd0;
        #2;
        reset_n = 1'b0;
        tick();
        tick();
        // Reset state
        check_idle("reset");
        chk("reset_out2", 32'(if2.out),      0);
        chk("reset_out8", 32'(if8.out),      0);
        chk("reset_cnt2", 32'(if2.done_cnt), 0);
        chk("reset_cnt8", 32'(if8.done_cnt), 0);
        reset_n = 1'b1;
        tick();
        check_idle("post_release");
        // Idle with in_valid low: nothing starts
        for (int i = 0; i < 10; i++) begin
            a_drv = 8'($urandom);
            b_drv = 8'($urandom);
            tick();
            chk($sformatf("idle_busy8_%0d", i),   32'(if8.busy),      0);
            chk($sformatf("idle_ready2_%0d", i),  32'(if2.in_ready),  1);
            chk($sformatf("idle_valid8_%0d", i),  32'(if8.out_valid), 0);
        end

        // Directed values: 3,1 -> 0 at 2 bits / 4 at 8 bits; 10,3 -> 14; 3,10 -> 242 (borrow wrap)
        run_txn(3, 1, 0);
        run_txn(10, 3, 0);
        run_txn(3, 10, 0);
        // Backpressure for 6 cycles
        run_txn(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 6);

        // Reset asserted while in SUM
        in_valid = 1'b1;
        a_drv    = 8'd77;
        b_drv    = 8'd5;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_abort_busy8", 32'(if8.busy), 1);
        reset_n = 1'b0;
        #1;
        cnt2 = 0;
        cnt8 = 0;
        check_idle("abort");
        chk("abort_out8", 32'(if8.out),      0);
        chk("abort_cnt2", 32'(if2.done_cnt), 0);
        chk("abort_cnt8", 32'(if8.done_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("abort_valid8_%0d", i), 32'(if8.out_valid), 0);
        end
        reset_n = 1'b1;
        tick();
        check_idle("abort_release");

        // Fresh transactions; four handoffs wrap the 2-bit counter to 0
        for (int i = 0; i < 4; i++) begin
            run_txn(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 2)));
        end
        chk("cnt2_wrap", 32'(if2.done_cnt), 32'(cnt2));
        chk("cnt8_four", 32'(if8.done_cnt), 32'(cnt8));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
